// File: rtl/bram_2kx9_sp_if.sv
// Port bundle for one 2K x 9 single-port RAM lane.
// The master drives address/data/control; the slave returns the registered read word.
interface bram_2kx9_sp_if;
  logic [10:0] addr_i;
  logic [7:0]  data_i;
  logic        par_i;
  logic        en_i;
  logic        we_i;
  logic [7:0]  data_o;
  logic        par_o;

  modport master (
    output addr_i, data_i, par_i, en_i, we_i,
    input  data_o, par_o
  );

  modport slave (
    input  addr_i, data_i, par_i, en_i, we_i,
    output data_o, par_o
  );
endinterface

// File: rtl/bram_2kx9_sp.sv
// 2048 x (8 data + 1 parity) single-port synchronous RAM.
// Behavioural model of a 16 Kb block RAM primitive in byte-wide mode.
// The read port is a single output register with a synchronous set/reset value.
// A write-mode parameter selects what that register shows during a write.
// Parity is stored and returned as a plain ninth bit; nothing is computed from it.
module bram_2kx9_sp #(
  parameter logic [8:0] INIT       = 9'h000,
  parameter logic [8:0] SRVAL      = 9'h000,
  parameter int         WRITE_MODE = 0,       // 0 write-first, 1 read-first, 2 no-change
  parameter logic [8:0] MEM_INIT   = 9'h000
) (
  input logic            clk_i,
  input logic            rst_i,
  bram_2kx9_sp_if.slave  bus
);

  typedef struct packed {
    logic       par;
    logic [7:0] data;
  } word_t;

  localparam int DEPTH = 2048;

  // Array and output register carry power-up values, like the primitive's
  // configuration bitstream; the reset input never touches the array.
  word_t mem [0:DEPTH-1] = '{default: word_t'(MEM_INIT)};
  word_t q               = word_t'(INIT);

  word_t wr_word;
  assign wr_word = '{par: bus.par_i, data: bus.data_i};

  // Array write: an enabled write lands even while the output reset is active.
  always_ff @(posedge clk_i) begin
    if (bus.en_i && bus.we_i)
      mem[bus.addr_i] <= wr_word;
  end

  // Output register: reset beats read, read beats the write-mode behaviour.
  // The read of mem here sees the value before this edge's write (old data).
  always_ff @(posedge clk_i) begin
    if (bus.en_i) begin
      if (rst_i)
        q <= word_t'(SRVAL);
      else if (!bus.we_i)
        q <= mem[bus.addr_i];
      else begin
        case (WRITE_MODE)
          0:       q <= wr_word;
          1:       q <= mem[bus.addr_i];
          default: q <= q;
        endcase
      end
    end
  end

  assign bus.data_o = q.data;
  assign bus.par_o  = q.par;

endmodule

// File: tb/tb_bram_2kx9_sp.sv
// Directed + random check of bram_2kx9_sp in all three write modes.
// Three instances share one set of inputs; each is checked against hand values.
module tb_bram_2kx9_sp;

  localparam logic [8:0] MI = 9'h1C3;   // common MEM_INIT

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        we  = 1'b0;
  logic [10:0] addr = '0;
  logic [8:0]  din  = '0;

  int checks   = 0;
  int failures = 0;
  logic [8:0] sb [0:2047];

  always #5 clk = ~clk;

  bram_2kx9_sp_if b_wf ();
  bram_2kx9_sp_if b_rf ();
  bram_2kx9_sp_if b_nc ();

  assign b_wf.addr_i = addr; assign b_wf.data_i = din[7:0]; assign b_wf.par_i = din[8];
  assign b_wf.en_i   = en;   assign b_wf.we_i   = we;
  assign b_rf.addr_i = addr; assign b_rf.data_i = din[7:0]; assign b_rf.par_i = din[8];
  assign b_rf.en_i   = en;   assign b_rf.we_i   = we;
  assign b_nc.addr_i = addr; assign b_nc.data_i = din[7:0]; assign b_nc.par_i = din[8];
  assign b_nc.en_i   = en;   assign b_nc.we_i   = we;

  bram_2kx9_sp #(.INIT(9'h12C), .SRVAL(9'h1FF), .WRITE_MODE(0), .MEM_INIT(MI))
    u_wf (.clk_i(clk), .rst_i(rst), .bus(b_wf));
  bram_2kx9_sp #(.INIT(9'h0A0), .SRVAL(9'h0AA), .WRITE_MODE(1), .MEM_INIT(MI))
    u_rf (.clk_i(clk), .rst_i(rst), .bus(b_rf));
  bram_2kx9_sp #(.INIT(9'h155), .SRVAL(9'h1FF), .WRITE_MODE(2), .MEM_INIT(MI))
    u_nc (.clk_i(clk), .rst_i(rst), .bus(b_nc));

  wire [8:0] q_wf = {b_wf.par_o, b_wf.data_o};
  wire [8:0] q_rf = {b_rf.par_o, b_rf.data_o};
  wire [8:0] q_nc = {b_nc.par_o, b_nc.data_o};

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge.
  task automatic cyc(input logic e, input logic w, input logic r,
                     input logic [10:0] a, input logic [8:0] d);
    @(negedge clk);
    en = e; we = w; rst = r; addr = a; din = d;
    @(posedge clk);
    if (e && w) sb[a] = d;
    #1;
  endtask

  task automatic chk3(input string tag, input logic [8:0] ewf,
                      input logic [8:0] erf, input logic [8:0] enc);
    chk({tag, "_wf"}, q_wf, ewf);
    chk({tag, "_rf"}, q_rf, erf);
    chk({tag, "_nc"}, q_nc, enc);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) sb[i] = MI;

    // power-up values before any clock
    #1;
    chk3("init", 9'h12C, 9'h0A0, 9'h155);

    // write/readback at both address extremes
    cyc(1, 1, 0, 11'h000, 9'h1A5);
    chk3("wr0", 9'h1A5, MI, 9'h155);
    cyc(1, 1, 0, 11'h7FF, 9'h03C);
    chk3("wr7ff", 9'h03C, MI, 9'h155);
    cyc(1, 0, 0, 11'h000, 9'h000);
    chk3("rd0", 9'h1A5, 9'h1A5, 9'h1A5);
    cyc(1, 0, 0, 11'h7FF, 9'h000);
    chk3("rd7ff", 9'h03C, 9'h03C, 9'h03C);

    // write-mode behaviour: addr 5 holds 0x11, then overwrite with 0x22
    cyc(1, 1, 0, 11'd5, 9'h011);
    cyc(1, 0, 0, 11'd5, 9'h000);
    chk3("rd5", 9'h011, 9'h011, 9'h011);
    cyc(1, 1, 0, 11'd5, 9'h022);
    chk3("wmode", 9'h022, 9'h011, 9'h011);
    cyc(1, 0, 0, 11'd5, 9'h000);
    chk3("rd5b", 9'h022, 9'h022, 9'h022);

    // synchronous reset, then reset together with a write
    cyc(1, 0, 1, 11'd0, 9'h000);
    chk3("srst", 9'h1FF, 9'h0AA, 9'h1FF);
    cyc(1, 1, 1, 11'd7, 9'h055);
    chk3("srst_wr", 9'h1FF, 9'h0AA, 9'h1FF);
    cyc(1, 0, 0, 11'd7, 9'h000);
    chk3("rd7", 9'h055, 9'h055, 9'h055);

    // enable gating: nothing moves with en low
    cyc(1, 0, 0, 11'd0, 9'h000);
    cyc(0, 1, 1, 11'd0, 9'h077);
    chk3("en0", 9'h1A5, 9'h1A5, 9'h1A5);
    cyc(0, 0, 0, 11'h7FF, 9'h000);
    chk3("en0_rd", 9'h1A5, 9'h1A5, 9'h1A5);
    cyc(1, 0, 0, 11'd0, 9'h000);
    chk3("en0_mem", 9'h1A5, 9'h1A5, 9'h1A5);

    // never-written word returns MEM_INIT
    cyc(1, 0, 0, 11'd1000, 9'h000);
    chk3("unwr", MI, MI, MI);

    // random traffic against the scoreboard; half the traffic in a small window
    for (int n = 0; n < 1000; n++) begin
      logic [10:0] a;
      logic [8:0]  d, old;
      logic        w;
      a   = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 31)) : 11'($urandom_range(0, 2047));
      d   = 9'($urandom);
      w   = ($urandom_range(0, 1) != 0);
      old = sb[a];
      cyc(1, w, 0, a, d);
      if (w) begin
        chk("rnd_wr_wf", q_wf, d);
        chk("rnd_wr_rf", q_rf, old);
      end else begin
        chk("rnd_rd_wf", q_wf, old);
        chk("rnd_rd_nc", q_nc, old);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
